// File: rtl/fft_pingpong_mem_pkg.sv
// Shared definitions for the ping-pong FFT butterfly memory:
// FSM state encoding, stage counter width helper and address bit-reversal.
package fft_pingpong_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fft_mem_state_t;

  // Width needed to hold stage values 0..n
  function automatic int stage_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Reverse the low w bits of a; bits above w are returned as zero
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r[i] = a[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dp_ram_bank.sv
// True dual-port synchronous RAM bank with registered reads.
// Both ports share one write enable. When both ports write the same
// address in one cycle, port 2 is applied last and its data is kept.
module dp_ram_bank #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] din_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] din_2,
  output logic [DATA_W-1:0] q_1,
  output logic [DATA_W-1:0] q_2
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage write, port 2 ordered after port 1 so it wins on collision
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_1] <= din_1;
      mem[addr_2] <= din_2;
    end
  end

  // Registered read for both ports
  always_ff @(posedge clk) begin
    q_1 <= mem[addr_1];
    q_2 <= mem[addr_2];
  end

endmodule

// File: rtl/fft_pingpong_mem.sv
// Ping-pong butterfly memory for a radix-2 FFT: two dual-port banks,
// one written and the other read per stage, with stage counting, bank
// select and read-valid pipelining kept here.
// Optional feature macro: FFT_MEM_BITREV_EN -- when defined, write
// addresses are bit-reversed while idle (natural-order input load).
module fft_pingpong_mem
  import fft_pingpong_mem_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int NUM_STAGES = 5,
  parameter int READ_LAT   = 1,
  parameter bit INIT_SEL   = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               swap,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  addw_1,
  input  logic [ADDR_W-1:0]                  addw_2,
  input  logic [DATA_W-1:0]                  din_1,
  input  logic [DATA_W-1:0]                  din_2,
  input  logic                               rd_en,
  input  logic [ADDR_W-1:0]                  addr_1,
  input  logic [ADDR_W-1:0]                  addr_2,
  output logic [DATA_W-1:0]                  dout_1,
  output logic [DATA_W-1:0]                  dout_2,
  output logic                               rd_valid,
  output logic                               select,
  output logic [stage_w(NUM_STAGES)-1:0]     stage,
  output logic                               last_stage,
  output logic                               done,
  output logic                               wr_collision
);

  localparam int STAGE_W = stage_w(NUM_STAGES);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  fft_mem_state_t     state_q;
  logic [STAGE_W-1:0] stage_q;
  logic               select_q;
  logic               done_q;
  logic               coll_q;

  logic [ADDR_W-1:0]  waddr_1, waddr_2;
  logic [ADDR_W-1:0]  addr_a_1, addr_a_2, addr_b_1, addr_b_2;
  logic               we_a, we_b;
  logic [DATA_W-1:0]  qa_1, qa_2, qb_1, qb_2;
  logic [DATA_W-1:0]  mux_1, mux_2;

  logic               vld_p0;
  logic               rsel_p0;

  // Transform control: start always wins, swap only counts while running
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      select_q <= INIT_SEL;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= ST_RUN;
        stage_q  <= '0;
        select_q <= INIT_SEL;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (swap) begin
              select_q <= ~select_q;
              if (stage_q == LAST_STAGE) begin
                state_q <= ST_DONE;
                stage_q <= '0;
                done_q  <= 1'b1;
              end else begin
                stage_q <= stage_q + 1'b1;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky flag for both write ports targeting the same address
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else if (we && (addw_1 == addw_2)) begin
      coll_q <= 1'b1;
    end
  end

`ifdef FFT_MEM_BITREV_EN
  // Natural-order input load lands in bit-reversed positions
  assign waddr_1 = (state_q == ST_IDLE) ? ADDR_W'(bitrev(32'(addw_1), ADDR_W)) : addw_1;
  assign waddr_2 = (state_q == ST_IDLE) ? ADDR_W'(bitrev(32'(addw_2), ADDR_W)) : addw_2;
`else
  assign waddr_1 = addw_1;
  assign waddr_2 = addw_2;
`endif

  // select=1: bank A is written, bank B is read; select=0: the reverse
  assign we_a     = we & select_q;
  assign we_b     = we & ~select_q;
  assign addr_a_1 = select_q ? waddr_1 : addr_1;
  assign addr_a_2 = select_q ? waddr_2 : addr_2;
  assign addr_b_1 = select_q ? addr_1  : waddr_1;
  assign addr_b_2 = select_q ? addr_2  : waddr_2;

  dp_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_a (
    .clk    (clk),
    .we     (we_a),
    .addr_1 (addr_a_1),
    .din_1  (din_1),
    .addr_2 (addr_a_2),
    .din_2  (din_2),
    .q_1    (qa_1),
    .q_2    (qa_2)
  );

  dp_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank_b (
    .clk    (clk),
    .we     (we_b),
    .addr_1 (addr_b_1),
    .din_1  (din_1),
    .addr_2 (addr_b_2),
    .din_2  (din_2),
    .q_1    (qb_1),
    .q_2    (qb_2)
  );

  // ---- stage p0: RAM read register; remember which bank was read at issue
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      rsel_p0 <= INIT_SEL;
    end else begin
      vld_p0  <= rd_en;
      rsel_p0 <= select_q;
    end
  end

  assign mux_1 = rsel_p0 ? qb_1 : qa_1;
  assign mux_2 = rsel_p0 ? qb_2 : qa_2;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              vld_p1;
      logic [DATA_W-1:0] dout_1_p1, dout_2_p1;

      // ---- stage p1: resettable output register
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1    <= 1'b0;
          dout_1_p1 <= '0;
          dout_2_p1 <= '0;
        end else begin
          vld_p1    <= vld_p0;
          dout_1_p1 <= mux_1;
          dout_2_p1 <= mux_2;
        end
      end

      assign dout_1   = dout_1_p1;
      assign dout_2   = dout_2_p1;
      assign rd_valid = vld_p1;
    end else begin : g_lat1
      assign dout_1   = mux_1;
      assign dout_2   = mux_2;
      assign rd_valid = vld_p0;
    end
  endgenerate

  assign select       = select_q;
  assign stage        = stage_q;
  assign last_stage   = (state_q == ST_RUN) && (stage_q == LAST_STAGE);
  assign done         = done_q;
  assign wr_collision = coll_q;

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// Directed self-checking bench for fft_pingpong_mem (default parameters).
// Exercises the FFT_MEM_BITREV_EN section only when that macro is defined.
module tb_fft_pingpong_mem;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, start, swap, we, rd_en;
  logic [ADDR_W-1:0] addw_1, addw_2, addr_1, addr_2;
  logic [DATA_W-1:0] din_1, din_2;
  logic [DATA_W-1:0] dout_1, dout_2;
  logic              rd_valid, select, last_stage, done, wr_collision;
  logic [2:0]        stage;

  int n_checks = 0;
  int n_errors = 0;

  fft_pingpong_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_STAGES(5), .READ_LAT(1), .INIT_SEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .swap(swap), .we(we),
    .addw_1(addw_1), .addw_2(addw_2), .din_1(din_1), .din_2(din_2),
    .rd_en(rd_en), .addr_1(addr_1), .addr_2(addr_2),
    .dout_1(dout_1), .dout_2(dout_2), .rd_valid(rd_valid), .select(select),
    .stage(stage), .last_stage(last_stage), .done(done), .wr_collision(wr_collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  initial begin
    rst = 1; start = 0; swap = 0; we = 0; rd_en = 0;
    addw_1 = '0; addw_2 = '0; addr_1 = '0; addr_2 = '0; din_1 = '0; din_2 = '0;
    tick(); tick();
    chk("rst_select", 64'(select), 64'd1);
    chk("rst_stage", 64'(stage), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_collision", 64'(wr_collision), 64'd0);
    chk("rst_last_stage", 64'(last_stage), 64'd0);
    rst = 0;

    // Start transform, fill bank A (select=1) two words per cycle
    start = 1; tick(); start = 0;
    chk("start_stage", 64'(stage), 64'd0);
    for (int k = 0; k < 16; k++) begin
      we = 1; addw_1 = 5'(2*k); addw_2 = 5'(2*k+1);
      din_1 = pat(2*k); din_2 = pat(2*k+1);
      tick();
    end
    we = 0;

    // Swap: bank A becomes the read bank
    swap = 1; tick(); swap = 0;
    chk("swap1_select", 64'(select), 64'd0);
    chk("swap1_stage", 64'(stage), 64'd1);

    for (int k = 0; k < 16; k++) begin
      rd_en = 1; addr_1 = 5'(2*k); addr_2 = 5'(2*k+1);
      tick();
      chk("rd_valid", 64'(rd_valid), 64'd1);
      chk("rd_dout_1", dout_1, pat(2*k));
      chk("rd_dout_2", dout_2, pat(2*k+1));
    end
    rd_en = 0; tick();
    chk("rd_idle_valid", 64'(rd_valid), 64'd0);

    // Write bank B (select=0), then read across a swap
    we = 1; addw_1 = 5'd3; addw_2 = 5'd4; din_1 = 64'hB3; din_2 = 64'hB4;
    tick(); we = 0;
    rd_en = 1; addr_1 = 5'd3; addr_2 = 5'd4; swap = 1;
    tick(); swap = 0;
    chk("swaprd_old_bank", dout_1, pat(3));
    chk("swaprd_select", 64'(select), 64'd1);
    tick();
    chk("swaprd_new_bank_1", dout_1, 64'hB3);
    chk("swaprd_new_bank_2", dout_2, 64'hB4);
    chk("swaprd_stage", 64'(stage), 64'd2);

    // Reset mid-transform with a read in flight
    chk("prerst_valid", 64'(rd_valid), 64'd1);
    rst = 1; rd_en = 0; tick(); rst = 0;
    chk("midrst_stage", 64'(stage), 64'd0);
    chk("midrst_valid", 64'(rd_valid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_select", 64'(select), 64'd1);

    // Full transform: 5 swaps
    start = 1; tick(); start = 0;
    chk("seq_stage0", 64'(stage), 64'd0);
    chk("seq_last0", 64'(last_stage), 64'd0);
    for (int s = 1; s <= 5; s++) begin
      swap = 1; tick();
      if (s < 5) begin
        chk("seq_stage", 64'(stage), 64'(s));
        chk("seq_last", 64'(last_stage), (s == 4) ? 64'd1 : 64'd0);
        chk("seq_done_low", 64'(done), 64'd0);
      end
    end
    swap = 0;
    chk("seq_done", 64'(done), 64'd1);
    chk("seq_end_select", 64'(select), 64'd0);
    chk("seq_end_last", 64'(last_stage), 64'd0);
    tick();
    chk("seq_done_pulse", 64'(done), 64'd0);
    swap = 1; tick(); swap = 0;
    chk("idle_swap_select", 64'(select), 64'd0);
    chk("idle_swap_stage", 64'(stage), 64'd0);

    // Write collision in IDLE (select=0 -> bank B)
    we = 1; addw_1 = 5'd7; addw_2 = 5'd7;
    din_1 = 64'hAAAA_AAAA_AAAA_AAAA; din_2 = 64'hBBBB_BBBB_BBBB_BBBB;
    tick(); we = 0;
    chk("coll_flag", 64'(wr_collision), 64'd1);
    start = 1; tick(); start = 0;
    rd_en = 1; addr_1 = 5'd7; addr_2 = 5'd7; tick(); rd_en = 0;
    chk("coll_data", dout_1, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("coll_sticky", 64'(wr_collision), 64'd1);

    // start and swap in the same cycle: start wins
    swap = 1; tick(); swap = 0;
    chk("pre_startswap_stage", 64'(stage), 64'd1);
    start = 1; swap = 1; tick(); start = 0; swap = 0;
    chk("startswap_stage", 64'(stage), 64'd0);
    chk("startswap_select", 64'(select), 64'd1);

    rst = 1; tick(); rst = 0;
    chk("coll_cleared", 64'(wr_collision), 64'd0);

`ifdef FFT_MEM_BITREV_EN
    // IDLE write to addr 1 lands at 16 in bank A
    we = 1; addw_1 = 5'd1; addw_2 = 5'd2; din_1 = 64'h1D1E; din_2 = 64'h2D1E;
    tick(); we = 0;
    start = 1; tick(); start = 0;
    swap = 1; tick(); swap = 0;
    rd_en = 1; addr_1 = 5'd16; addr_2 = 5'd8; tick(); rd_en = 0;
    chk("bitrev_idle_1", dout_1, 64'h1D1E);
    chk("bitrev_idle_2", dout_2, 64'h2D1E);
    // RUN write to addr 1 lands at 1 in bank B
    we = 1; addw_1 = 5'd1; addw_2 = 5'd9; din_1 = 64'h0123; din_2 = 64'h0999;
    tick(); we = 0;
    swap = 1; tick(); swap = 0;
    rd_en = 1; addr_1 = 5'd1; addr_2 = 5'd9; tick(); rd_en = 0;
    chk("bitrev_run_1", dout_1, 64'h0123);
    chk("bitrev_run_2", dout_2, 64'h0999);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
